// File: rtl/data_ram_if.sv
// data_ram_if: request/response bundle between a core memory stage and data_ram.
// The master side issues valid/ready requests; the slave side returns a
// registered one-cycle response pulse plus the init_done status flag.
interface data_ram_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_ctrl;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        init_done;

    modport master (
        output req_valid, req_we, req_ctrl, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_ctrl, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, init_done
    );
endinterface

// File: rtl/data_ram.sv
// data_ram: byte-addressed 32-bit data memory with B/H/W loads and stores,
// sign/zero extension, a registered response, range and illegal-ctrl error
// reporting and a post-reset zero-fill sweep.
// Optional macro DATA_RAM_MISALIGN_TRAP_EN: when defined, misaligned halfword
// and word accesses are reported as errors; otherwise they are aligned down.
module data_ram #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic       clk,
    input logic       rst_n,
    data_ram_if.slave bus
);
    localparam int PTR_W = ADDR_W - 2;
    localparam int DEPTH = 1 << PTR_W;
    localparam logic [PTR_W-1:0] LAST_WORD = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] sweep_ptr;
    logic [PTR_W-1:0] sweep_ptr_nxt;
    logic             run;

    logic [31:0] mem [DEPTH];

    logic [1:0]       size;
    logic             is_unsigned;
    logic             illegal_ctrl;
    logic             range_err;
    logic             access_err;
    logic             accept;
    logic             store_en;
    logic [PTR_W-1:0] word_idx;
    logic [1:0]       lane;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_data;

    assign size        = bus.req_ctrl[1:0];
    assign is_unsigned = bus.req_ctrl[2];
    assign word_idx    = bus.req_addr[ADDR_W-1:2];
    assign lane        = bus.req_addr[1:0];

    // Unsigned variants exist only for B/H loads; size code 11 is never legal.
    assign illegal_ctrl = (size == 2'b11) || (is_unsigned && (bus.req_we || size == 2'b10));
    assign range_err    = (bus.req_addr[31:ADDR_W] != BASE_ADDR[31:ADDR_W]);

`ifdef DATA_RAM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = ((size == 2'b01) && bus.req_addr[0]) ||
                        ((size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    assign access_err = illegal_ctrl || range_err || misaligned;
`else
    assign access_err = illegal_ctrl || range_err;
`endif

    assign accept   = bus.req_valid && run;
    assign store_en = accept && bus.req_we && !access_err;

    assign bus.req_ready = run;
    assign bus.init_done = run;

    // State register: sweep pointer and INIT/RUN phase, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
        end else begin
            state     <= state_nxt;
            sweep_ptr <= sweep_ptr_nxt;
        end
    end

    // Next state: INIT walks the pointer over every word, then RUN forever.
    always_comb begin
        state_nxt     = state;
        sweep_ptr_nxt = sweep_ptr;
        run           = 1'b0;
        case (state)
            ST_INIT: begin
                sweep_ptr_nxt = sweep_ptr + PTR_W'(1);
                if (sweep_ptr == LAST_WORD) begin
                    state_nxt     = ST_RUN;
                    sweep_ptr_nxt = '0;
                end
            end
            ST_RUN: begin
                run = 1'b1;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Store lane enables and lane-replicated write data for B/H/W stores.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = {4{bus.req_wdata[7:0]}};
        case (size)
            2'b00: wr_be = 4'b0001 << lane;
            2'b01: begin
                wr_be   = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                wr_be   = 4'b1111;
                wr_data = bus.req_wdata;
            end
            default: wr_be = 4'b0000;
        endcase
    end

    // Load path: pick byte/halfword by lane and extend per the ctrl code.
    always_comb begin
        rd_word   = mem[word_idx];
        rd_byte   = rd_word[{lane, 3'b000} +: 8];
        rd_half   = bus.req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = 32'h0;
        case (size)
            2'b00:   load_data = is_unsigned ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_data = is_unsigned ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            2'b10:   load_data = rd_word;
            default: load_data = 32'h0;
        endcase
    end

    // Storage: zero-fill during INIT, byte-enabled stores in RUN (no reset on the array).
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[sweep_ptr] <= 32'h0;
        end else if (store_en) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    mem[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // Response register: one-cycle pulse per accepted request, data only for good loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'h0;
            bus.resp_err   <= 1'b0;
        end else begin
            bus.resp_valid <= accept;
            bus.resp_err   <= accept && access_err;
            bus.resp_rdata <= (accept && !bus.req_we && !access_err) ? load_data : 32'h0;
        end
    end
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: randomized scoreboard bench for data_ram. Expected responses
// come from a byte-array reference model and are queued at issue time; a
// negedge monitor pops and compares them whenever resp_valid is seen.
// Honours DATA_RAM_MISALIGN_TRAP_EN in the model when it is defined.
module tb_data_ram;
    localparam int          ADDR_W    = 10;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int          MEM_BYTES = 1 << ADDR_W;
    localparam int          DEPTH     = MEM_BYTES / 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned cycle_cnt = 0;

    logic [7:0] model_mem [MEM_BYTES];
    exp_t       exp_q [$];
    exp_t       mon_e;

    data_ram_if bus ();

    data_ram #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Free-running cycle count used to check response latency.
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
    endtask

    // Reference model: byte array, plain arithmetic on size and offset.
    function automatic void model_access(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                                         input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int          size;
        bit          sext;
        bit          illegal;
        int          offset;
        int          base;
        logic [31:0] val;
        size    = 1;
        sext    = 1'b0;
        illegal = 1'b0;
        case (ctrl)
            3'b000:  begin size = 1; sext = 1'b1; end
            3'b001:  begin size = 2; sext = 1'b1; end
            3'b010:  size = 4;
            3'b100:  begin size = 1; illegal = we; end
            3'b101:  begin size = 2; illegal = we; end
            default: illegal = 1'b1;
        endcase
        err    = illegal || ((addr / 32'(MEM_BYTES)) != (BASE / 32'(MEM_BYTES)));
        offset = int'(addr % 32'(MEM_BYTES));
`ifdef DATA_RAM_MISALIGN_TRAP_EN
        if (offset % size != 0) err = 1'b1;
        base = offset;
`else
        base = offset - (offset % size);
`endif
        rdata = 32'h0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < size; i++) model_mem[base + i] = 8'(wdata >> (8 * i));
        end else begin
            val = 32'h0;
            for (int i = 0; i < size; i++) val = val | (32'(model_mem[base + i]) << (8 * i));
            if (sext && val[8 * size - 1]) begin
                for (int b = 8 * size; b < 32; b++) val[b] = 1'b1;
            end
            rdata = val;
        end
    endfunction

    // Drive one request at the falling edge; queue its expected response if it will be accepted.
    task automatic applyStimulus(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit expect_accept);
        exp_t e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_ctrl  = ctrl;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        if (expect_accept) begin
            model_access(we, ctrl, addr, wdata, e.rdata, e.err);
            e.cyc = cycle_cnt + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    // Count cycles until req_ready; optionally poke a store that must be ignored during INIT.
    task automatic waitInit(input bit poke);
        int n;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 10) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_ctrl  = 3'b010;
                bus.req_addr  = 32'h40;
                bus.req_wdata = 32'hDEAD_BEEF;
            end
            if (poke && n == 12) bus.req_valid = 1'b0;
        end
        checkOutput("init_cycles", 32'(n), 32'(DEPTH));
        checkOutput("ready_after_init", 32'(bus.req_ready), 32'h1);
        checkOutput("init_done_after_init", 32'(bus.init_done), 32'h1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
        checkOutput({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'h0);
        checkOutput({tag, "_resp_rdata"}, bus.resp_rdata, 32'h0);
        checkOutput({tag, "_resp_err"}, 32'(bus.resp_err), 32'h0);
        checkOutput({tag, "_init_done"}, 32'(bus.init_done), 32'h0);
    endtask

    // Monitor: every observed response must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("[TB] FAIL unexpected_resp: actual resp_valid=1 rdata=0x%08h, required no response",
                         bus.resp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("resp_rdata", bus.resp_rdata, mon_e.rdata);
                checkOutput("resp_err", 32'(bus.resp_err), 32'(mon_e.err));
                checkOutput("resp_latency", cycle_cnt, mon_e.cyc);
            end
        end
    end

    // Watchdog so a stuck DUT still ends the run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed test-plan cases, random traffic, mid-operation reset.
    initial begin
        logic [31:0] a;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_ctrl  = 3'b010;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        waitInit(1'b1);

        $display("[TB] directed cases");
        applyStimulus(1'b0, 3'b010, 32'h3FC, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'b010, 32'h10, 32'h8000_00FF, 1'b1);
        applyStimulus(1'b0, 3'b000, 32'h10, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b001, 32'h12, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b101, 32'h10, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'b010, 32'h20, 32'h1122_3344, 1'b1);
        applyStimulus(1'b1, 3'b000, 32'h21, 32'h0000_00AB, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h400, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'b010, 32'h400, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b011, 32'h0, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'b100, 32'h24, 32'h5A5A_5A5A, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h22, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'b001, 32'h23, 32'h0000_5555, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h24, 32'h0, 1'b1);
        idle();
        repeat (3) @(posedge clk);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle();
            end else begin
                case ($urandom_range(0, 9))
                    0:       a = $urandom;
                    1:       a = 32'($urandom_range(0, MEM_BYTES - 1));
                    2:       a = 32'h400 + 32'($urandom_range(0, 15));
                    default: a = 32'($urandom_range(0, 63));
                endcase
                applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b1);
            end
        end
        idle();
        repeat (3) @(posedge clk);

        $display("[TB] reset during a load");
        applyStimulus(1'b1, 3'b010, 32'h8, 32'hCAFE_BABE, 1'b1);
        applyStimulus(1'b1, 3'b010, 32'h3FC, 32'h1234_5678, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        checkResetOutputs("midreset");
        checkOutput("pending_at_reset", 32'(exp_q.size()), 32'h0);
        for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        waitInit(1'b0);
        applyStimulus(1'b0, 3'b010, 32'h8, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h3FC, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        idle();
        repeat (3) @(posedge clk);
        checkOutput("pending_at_end", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/data_ram.md
# data_ram

Parametrised, byte-addressed 32-bit data memory for the single-cycle and pipelined cores. It supports RISC-V-style byte, halfword and word loads and stores with sign or zero extension. It adds a valid/ready request port, a registered read response, address-range and misalignment error reporting, and a post-reset zero-fill sweep. It sits between the core's memory stage and the data bus.

## Interface
- ADDR_W, 10: byte-address bits decoded; capacity 2^ADDR_W bytes; DEPTH = 2^(ADDR_W-2) words; legal range 4..16
- BASE_ADDR, 32'h0000_0000: base of the window; must be aligned to 2^ADDR_W
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_we  in  1  1 = store, 0 = load
- req_ctrl  in  3  size/extension: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 for stores; other codes are illegal
- req_addr  in  32  byte address
- req_wdata  in  32  store data, LSB-aligned
- resp_valid  out  1  one-cycle pulse per accepted request
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  out-of-range, illegal ctrl, or (with trap) misaligned
- init_done  out  1  zero-fill sweep complete

## Operation
- Storage: DEPTH x 32-bit words; byte lane k holds byte address 4*word+k (little-endian).
- FSM states:
  - INIT: entered on reset. Sweep pointer 0..DEPTH-1 writes one zero word per cycle. req_ready=0.
  - INIT to RUN: after the write of word DEPTH-1.
  - RUN: req_ready=1 and init_done=1. Stays in RUN until reset.
- Range check: error if req_addr[31:ADDR_W] != BASE_ADDR[31:ADDR_W]. Word index = req_addr[ADDR_W-1:2]; lane = req_addr[1:0].
- Illegal ctrl (011, 110, 111, or 1xx with req_we=1): error.
- Store, no error:
  - B writes lane addr[1:0] with wdata[7:0].
  - H writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - W writes all lanes.
  - Other lanes are untouched.
- Load, no error: select byte/halfword/word by lane; B/H sign-extend from bit 7/15; BU/HU zero-extend.
- Any error: no write occurs; resp_rdata=0; resp_err=1.
- Misalignment handling depends on DATA_RAM_MISALIGN_TRAP_EN (see Configuration).

## Timing
- Reset values:
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0
  - state=INIT, sweep pointer=0
  - Memory contents are not reset asynchronously; the sweep clears them.
- INIT lasts exactly DEPTH cycles after rst_n deasserts. req_ready rises on cycle DEPTH.
- Latency: a request accepted at edge N produces resp_valid, resp_rdata and resp_err valid after edge N+1, for exactly one cycle.
- Stores commit at acceptance edge N.
- Throughput: one request per cycle; the response port has no backpressure.
- Back-to-back store then load to the same word: the load at N+1 returns the stored value (write-before-read ordering).
- A load and a store in the same cycle are impossible (single port).
- Reset asserted mid-operation: all outputs return to reset values immediately. Any in-flight response is dropped. INIT restarts from pointer 0.
- req_valid is ignored while req_ready=0; no response is generated for it.

## Configuration
- DATA_RAM_MISALIGN_TRAP_EN defined:
  - A halfword with addr[0]=1 or a word with addr[1:0]!=0 is an error.
  - No write; resp_rdata=0; resp_err=1.
- Not defined:
  - Misaligned halfword/word accesses are aligned down: halfword lane uses addr[1] only; word ignores addr[1:0].
  - resp_err=0.
- Range and illegal-ctrl errors are unaffected by the macro.

## Test plan
- Reset, ADDR_W=10: req_ready=0 for 256 cycles, then req_ready=1 and init_done=1. A LW at 0x3FC returns 0.
- SW 0x8000_00FF to 0x10, then LB 0x10 -> 0xFFFF_FFFF; LBU 0x13 -> 0x0000_0080; LH 0x12 -> 0xFFFF_8000; LHU 0x10 -> 0x0000_00FF, each one cycle after acceptance.
- SB 0xAB to 0x21 over word 0x11223344 at 0x20, then LW 0x20 -> 0x1122AB44. Store responses carry resp_rdata=0, resp_err=0.
- LW to 0x400 (BASE_ADDR=0) -> resp_err=1, rdata 0. SW to 0x400 followed by LW 0x0 shows the memory unchanged. Ctrl 011 -> resp_err=1.
- LW at 0x22:
  - With trap: resp_err=1, rdata 0.
  - Without trap: returns the word at 0x20, resp_err=0.
  - SH at 0x23 with trap leaves memory unchanged.
- Reset pulsed the cycle after a load is accepted: no resp_valid. INIT reruns for the full DEPTH cycles and memory reads 0 afterwards.
